// File: rtl/setpoint_table_seq.sv
// Setpoint source: per-channel point registers or table sequencer,
// configured over an Avalon-MM slave.
module setpoint_table_seq #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          writedata,
    input  logic                       write,
    input  logic                       read,
    output logic [DATA_W-1:0]          readdata,
    output logic                       readdatavalid,
    output logic [CHANNELS*DATA_W-1:0] set_out,
    output logic                       set_valid,
    output logic                       busy,
    output logic                       done
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int PG_W  = ADDR_W - 12;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_HOLD, S_DONE
    } state_t;

    state_t                     r_state, w_state_nx;
    logic [IDX_W-1:0]           r_idx, w_idx_nx;
    logic [15:0]                r_cnt, w_cnt_nx;
    logic                       r_mode, r_run, r_loop;
    logic                       r_done, r_addr_err;
    logic [LEN_W-1:0]           r_length;
    logic [15:0]                r_dwell;
    logic [DATA_W-1:0]          r_point [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] r_set_out;
    logic                       r_set_valid;
    logic [DATA_W-1:0]          r_rd_reg;
    logic                       r_rd_tbl, r_rdv;
    logic [PG_W-1:0]            r_rd_pg;
    logic [DATA_W-1:0]          w_rda [CHANNELS];
    logic [DATA_W-1:0]          w_rdb [CHANNELS];

    logic [PG_W-1:0]   w_pg;
    logic [11:0]       w_off;
    logic [IDX_W-1:0]  w_ti;
    logic              w_tbl_hit, w_pt_hit, w_reg_hit, w_mapped, w_err;
    logic              w_wr, w_rd, w_ctrl_we, w_len_we, w_dwell_we, w_pt_we;
    logic              w_start, w_mode_up, w_abort, w_more;
    logic              w_latch, w_step_end;
    logic [DATA_W-1:0] w_status, w_rd_val;

    assign w_pg      = address[ADDR_W-1:12];
    assign w_off     = address[11:0];
    assign w_ti      = address[IDX_W-1:0];
    assign w_tbl_hit = (w_pg != '0) && (32'(w_pg) <= CHANNELS)
                       && (32'(w_off) < DEPTH);
    assign w_pt_hit  = (address[ADDR_W-1:4] == (ADDR_W-4)'(1))
                       && (32'(address[3:0]) < CHANNELS);
    assign w_reg_hit = (address[ADDR_W-1:2] == '0);
    assign w_mapped  = w_tbl_hit | w_pt_hit | w_reg_hit;
    assign w_err     = (write | read) & ~w_mapped;
    assign w_wr      = write & w_mapped;
    assign w_rd      = read & ~write;

    assign w_ctrl_we  = w_wr && (address == ADDR_W'(0));
    assign w_len_we   = w_wr && (address == ADDR_W'(2));
    assign w_dwell_we = w_wr && (address == ADDR_W'(3));
    assign w_pt_we    = w_wr && w_pt_hit;

    assign w_start   = w_ctrl_we & writedata[1] & ~writedata[0];
    assign w_mode_up = w_ctrl_we & writedata[0] & ~r_mode;
    assign w_abort   = w_mode_up | (w_ctrl_we & ~writedata[1]);
    assign w_more    = ({1'b0, r_idx} + LEN_W'(1)) < r_length;

    assign busy = (r_state == S_FETCH) || (r_state == S_LATCH)
                  || (r_state == S_HOLD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ram
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_rda, r_rdb;
        logic              w_sel;
        assign w_sel = w_tbl_hit && (w_pg == PG_W'(c + 1));
        // Port A host, port B sequencer; both read-before-write
        always_ff @(posedge clk) begin
            if (w_sel && write) r_mem[w_ti] <= writedata;
            else if (w_sel && read) r_rda <= r_mem[w_ti];
            r_rdb <= r_mem[r_idx];
        end
        assign w_rda[c] = r_rda;
        assign w_rdb[c] = r_rdb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_latch    = 1'b0;
        w_step_end = 1'b0;
        unique case (r_state)
            S_IDLE:  ;
            S_FETCH: w_state_nx = S_LATCH;
            S_LATCH: begin
                w_latch  = 1'b1;
                w_cnt_nx = r_dwell;
                if (r_dwell == '0) w_step_end = 1'b1;
                else w_state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt > 16'd1) begin
                    w_cnt_nx = r_cnt - 16'd1;
                end else begin
                    w_cnt_nx   = '0;
                    w_step_end = 1'b1;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (w_step_end) begin
            if (w_more) begin
                w_idx_nx   = r_idx + IDX_W'(1);
                w_state_nx = S_FETCH;
            end else if (r_loop) begin
                w_idx_nx   = '0;
                w_state_nx = S_FETCH;
            end else begin
                w_state_nx = S_DONE;
            end
        end
        // Host control overrides the sequencer on the same edge
        if (w_start) begin
            w_idx_nx   = '0;
            w_cnt_nx   = '0;
            w_latch    = 1'b0;
            w_state_nx = (r_length == '0) ? S_DONE : S_FETCH;
        end else if (w_abort) begin
            w_latch    = 1'b0;
            w_state_nx = S_IDLE;
        end
    end

    always_comb begin
        w_status           = '0;
        w_status[0]        = busy;
        w_status[1]        = r_done;
        w_status[2]        = r_addr_err;
        w_status[8 +: IDX_W] = r_idx;
        w_rd_val           = '0;
        if (address == ADDR_W'(0))
            w_rd_val = DATA_W'({r_loop, r_run, r_mode});
        else if (address == ADDR_W'(1))
            w_rd_val = w_status;
        else if (address == ADDR_W'(2))
            w_rd_val = DATA_W'(r_length);
        else if (address == ADDR_W'(3))
            w_rd_val = DATA_W'(r_dwell);
        for (int c = 0; c < CHANNELS; c++)
            if (w_pt_hit && address[3:0] == 4'(c)) w_rd_val = r_point[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= 1'b0;
            r_run       <= 1'b0;
            r_loop      <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
            r_length    <= '0;
            r_dwell     <= '0;
            r_set_out   <= '0;
            r_set_valid <= 1'b0;
            r_rd_reg    <= '0;
            r_rd_tbl    <= 1'b0;
            r_rd_pg     <= '0;
            r_rdv       <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) r_point[c] <= '0;
        end else begin
            r_set_valid <= w_latch | (w_pt_we & r_mode) | w_mode_up;
            r_rdv       <= w_rd;
            if (w_rd) begin
                r_rd_tbl <= w_tbl_hit;
                r_rd_pg  <= w_pg;
                r_rd_reg <= w_rd_val;
            end
            if (r_state == S_DONE) r_done <= 1'b1;
            if (w_start | w_mode_up) r_done <= 1'b0;
            if (r_state == S_DONE && !w_ctrl_we) r_run <= 1'b0;
            if (w_ctrl_we) begin
                r_mode <= writedata[0];
                r_run  <= writedata[1];
                r_loop <= writedata[2];
            end
            if (w_err) r_addr_err <= 1'b1;
            else if (w_ctrl_we && writedata[3]) r_addr_err <= 1'b0;
            if (w_len_we)
                r_length <= (writedata > DATA_W'(DEPTH)) ? LEN_W'(DEPTH)
                                                         : writedata[LEN_W-1:0];
            if (w_dwell_we) r_dwell <= writedata[15:0];
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_pt_we && address[3:0] == 4'(c)) begin
                    r_point[c] <= writedata;
                    if (r_mode) r_set_out[c*DATA_W +: DATA_W] <= writedata;
                end
                if (w_mode_up) r_set_out[c*DATA_W +: DATA_W] <= r_point[c];
                if (w_latch) r_set_out[c*DATA_W +: DATA_W] <= w_rdb[c];
            end
        end
    end

    always_comb begin
        readdata = r_rd_reg;
        if (r_rd_tbl)
            for (int c = 0; c < CHANNELS; c++)
                if (r_rd_pg == PG_W'(c + 1)) readdata = w_rda[c];
    end

    assign readdatavalid = r_rdv;
    assign set_out       = r_set_out;
    assign set_valid     = r_set_valid;
    assign done          = r_done;
endmodule

// File: tb/tb_setpoint_table_seq.sv
// Directed bench for setpoint_table_seq: register vectors plus
// hand-written sequencer, error and reset scenarios.
module tb_setpoint_table_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic [31:0] writedata;
    logic        write, read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [95:0] set_out;
    logic        set_valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] sv_val[$];
    int          sv_cyc[$];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[26];

    setpoint_table_seq dut (
        .clk(clk), .rst(rst), .address(address), .writedata(writedata),
        .write(write), .read(read), .readdata(readdata),
        .readdatavalid(readdatavalid), .set_out(set_out),
        .set_valid(set_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk)
        if (set_valid === 1'b1) begin
            sv_val.push_back(set_out[31:0]);
            sv_cyc.push_back(cyc);
        end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d,
                      output logic v);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata; v = readdatavalid;
    endtask

    task automatic wait_done(input int lim, input string nm);
        int k = 0;
        while (done !== 1'b1 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 64'(done), 64'd1);
    endtask

    function automatic logic [31:0] qv(input int i);
        return (i < sv_val.size()) ? sv_val[i] : 32'hffff_ffff;
    endfunction

    function automatic int qc(input int i);
        return (i < sv_cyc.size()) ? sv_cyc[i] : -1000;
    endfunction

    logic [31:0] rdat;
    logic        rv;
    logic [95:0] snap;
    int          n0, k0;

    initial begin
        vecs[0]  = '{1'b1, 16'h1000, 32'd10, 32'd0};
        vecs[1]  = '{1'b1, 16'h1001, 32'd20, 32'd0};
        vecs[2]  = '{1'b1, 16'h1002, 32'd30, 32'd0};
        vecs[3]  = '{1'b1, 16'h1003, 32'd40, 32'd0};
        vecs[4]  = '{1'b0, 16'h1002, 32'd0, 32'd30};
        vecs[5]  = '{1'b0, 16'h1000, 32'd0, 32'd10};
        vecs[6]  = '{1'b1, 16'h0002, 32'd300, 32'd0};
        vecs[7]  = '{1'b0, 16'h0002, 32'd0, 32'd256};
        vecs[8]  = '{1'b1, 16'h0002, 32'd4, 32'd0};
        vecs[9]  = '{1'b0, 16'h0002, 32'd0, 32'd4};
        vecs[10] = '{1'b1, 16'h0003, 32'h12345, 32'd0};
        vecs[11] = '{1'b0, 16'h0003, 32'd0, 32'h2345};
        vecs[12] = '{1'b1, 16'h0003, 32'd3, 32'd0};
        vecs[13] = '{1'b0, 16'h0003, 32'd0, 32'd3};
        vecs[14] = '{1'b1, 16'h0012, 32'hdeadbeef, 32'd0};
        vecs[15] = '{1'b0, 16'h0012, 32'd0, 32'hdeadbeef};
        vecs[16] = '{1'b1, 16'h30ff, 32'ha5a5a5a5, 32'd0};
        vecs[17] = '{1'b0, 16'h30ff, 32'd0, 32'ha5a5a5a5};
        vecs[18] = '{1'b1, 16'h0013, 32'h77, 32'd0};
        vecs[19] = '{1'b0, 16'h0013, 32'd0, 32'd0};
        vecs[20] = '{1'b0, 16'h1100, 32'd0, 32'd0};
        vecs[21] = '{1'b0, 16'h0000, 32'd0, 32'd1};
        vecs[22] = '{1'b0, 16'h0001, 32'd0, 32'd4};
        vecs[23] = '{1'b1, 16'h0000, 32'd9, 32'd0};
        vecs[24] = '{1'b0, 16'h0001, 32'd0, 32'd0};
        vecs[25] = '{1'b0, 16'h0000, 32'd0, 32'd1};

        rst = 1'b1; address = '0; writedata = '0; write = 1'b0; read = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst set_out", 64'(set_out), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst rdv", 64'(readdatavalid), 64'd0);
        rd(16'h0001, rdat, rv);
        chk("rst status", 64'(rdat), 64'd0);

        // point mode
        wr(16'h0000, 32'h1);
        @(negedge clk);
        n0 = sv_val.size();
        wr(16'h0011, 32'h1234);
        chk("pt set_out1", 64'(set_out[63:32]), 64'h1234);
        chk("pt valid hi", 64'(set_valid), 64'd1);
        @(negedge clk);
        chk("pt valid lo", 64'(set_valid), 64'd0);
        repeat (2) @(negedge clk);
        chk("pt pulses", 64'(sv_val.size() - n0), 64'd1);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, rdat, rv);
                chk($sformatf("vec%0d rdv", i), 64'(rv), 64'd1);
                chk($sformatf("vec%0d data", i), 64'(rdat), 64'(vecs[i].exp));
            end
        end

        // one-shot, LENGTH=4, DWELL=3
        sv_val.delete(); sv_cyc.delete();
        wr(16'h0000, 32'h2);
        k0 = cyc;
        chk("os busy", 64'(busy), 64'd1);
        wait_done(60, "os done");
        chk("os count", 64'(sv_val.size()), 64'd4);
        chk("os first lat", 64'(qc(0) - k0), 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("os val%0d", i), 64'(qv(i)), 64'(10 * (i + 1)));
            if (i > 0)
                chk($sformatf("os per%0d", i), 64'(qc(i) - qc(i - 1)), 64'd5);
        end
        chk("os busy end", 64'(busy), 64'd0);
        rd(16'h0000, rdat, rv);
        chk("os run clr", 64'(rdat), 64'd0);

        // loop then stop
        wr(16'h0002, 32'd2);
        sv_val.delete(); sv_cyc.delete();
        wr(16'h0000, 32'h6);
        repeat (22) @(negedge clk);
        chk("lp v0", 64'(qv(0)), 64'd10);
        chk("lp v1", 64'(qv(1)), 64'd20);
        chk("lp v2", 64'(qv(2)), 64'd10);
        chk("lp v3", 64'(qv(3)), 64'd20);
        @(negedge clk);
        address = 16'h0000; writedata = 32'h4; write = 1'b1;
        snap = set_out;
        @(negedge clk);
        write = 1'b0;
        chk("stop busy", 64'(busy), 64'd0);
        chk("stop held", 64'(set_out), 64'(snap));
        n0 = sv_val.size();
        repeat (10) @(negedge clk);
        chk("stop quiet", 64'(sv_val.size() - n0), 64'd0);
        chk("stop held2", 64'(set_out), 64'(snap));
        chk("stop done", 64'(done), 64'd0);

        // address errors
        rd(16'h4001, rdat, rv);
        chk("err data", 64'(rdat), 64'd0);
        chk("err rdv", 64'(rv), 64'd1);
        rd(16'h0001, rdat, rv);
        chk("err flag", 64'(rdat[2]), 64'd1);
        wr(16'h0000, 32'h8);
        rd(16'h0001, rdat, rv);
        chk("err clr", 64'(rdat[2]), 64'd0);

        // LENGTH=0 start
        wr(16'h0002, 32'd0);
        sv_val.delete(); sv_cyc.delete();
        wr(16'h0000, 32'h2);
        repeat (2) @(negedge clk);
        chk("len0 done", 64'(done), 64'd1);
        chk("len0 busy", 64'(busy), 64'd0);
        chk("len0 novalid", 64'(sv_val.size()), 64'd0);

        // write and read in one cycle
        @(negedge clk);
        address = 16'h0003; writedata = 32'd7; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        chk("wr+rd rdv", 64'(readdatavalid), 64'd0);
        rd(16'h0003, rdat, rv);
        chk("wr+rd data", 64'(rdat), 64'd7);

        // DWELL=0: two-cycle steps
        wr(16'h0003, 32'd0);
        wr(16'h0002, 32'd3);
        sv_val.delete(); sv_cyc.delete();
        wr(16'h0000, 32'h2);
        k0 = cyc;
        wait_done(40, "dw0 done");
        chk("dw0 count", 64'(sv_val.size()), 64'd3);
        chk("dw0 first", 64'(qc(0) - k0), 64'd2);
        chk("dw0 v2", 64'(qv(2)), 64'd30);
        chk("dw0 per", 64'(qc(2) - qc(1)), 64'd2);

        // reset mid-run
        wr(16'h0003, 32'd3);
        wr(16'h0002, 32'd4);
        wr(16'h0000, 32'h2);
        repeat (8) @(negedge clk);
        chk("mid busy", 64'(busy), 64'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid set_out", 64'(set_out), 64'd0);
        chk("mid busy0", 64'(busy), 64'd0);
        chk("mid done0", 64'(done), 64'd0);
        rd(16'h0001, rdat, rv);
        chk("mid status", 64'(rdat), 64'd0);
        rd(16'h0002, rdat, rv);
        chk("mid length", 64'(rdat), 64'd0);
        rd(16'h0011, rdat, rv);
        chk("mid point1", 64'(rdat), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
